// File: rtl/first_counter_checker.sv
// rtl/first_counter_checker.sv - cycle-accurate reference checker for a 4-bit enable counter
module first_counter_checker #(
  parameter int WIDTH     = 4,
  parameter int ERR_W     = 8,
  parameter int ERR_LIMIT = 4,
  parameter int RESYNC    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] counter_out,
  output logic             in_sync,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic [ERR_W-1:0] error_count,
  output logic [7:0]       wrap_count,
  output logic [WIDTH-1:0] first_bad,
  output logic [WIDTH-1:0] first_exp,
  output logic             fail
);

  typedef enum logic [1:0] {
    S_UNSYNC = 2'd0,
    S_TRACK  = 2'd1,
    S_FAIL   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(ERR_LIMIT);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic             mm_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic [7:0]       wrap_nxt;
  logic [WIDTH-1:0] fb_nxt;
  logic [WIDTH-1:0] fe_nxt;
  logic             bad;
  logic             reload;
  logic [WIDTH-1:0] base;

  assign in_sync = (state != S_UNSYNC);
  assign fail    = (state == S_FAIL);

  // State register: asynchronous clear back to UNSYNC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_UNSYNC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic: compare, model step, statistics.
  always_comb begin
    state_nxt = state;
    exp_nxt   = expected;
    mm_nxt    = 1'b0;
    err_nxt   = error_count;
    wrap_nxt  = wrap_count;
    fb_nxt    = first_bad;
    fe_nxt    = first_exp;
    bad       = 1'b0;
    reload    = 1'b0;
    base      = expected;
    unique case (state)
      S_UNSYNC: begin
        if (dut_reset) begin
          state_nxt = S_TRACK;
          exp_nxt   = '0;
        end
      end
      S_TRACK: begin
        bad    = (counter_out != expected);
        reload = bad && (RESYNC != 0);
        mm_nxt = bad;
        if (bad) begin
          if (error_count != ERR_MAX) begin
            err_nxt = error_count + ERR_ONE;
          end
          if (error_count == '0) begin
            fb_nxt = counter_out;
            fe_nxt = expected;
          end
        end
        // After a mismatch the model optionally restarts from what was observed.
        base = reload ? counter_out : expected;
        if (dut_reset) begin
          exp_nxt = '0;
        end else if (enable) begin
          exp_nxt = base + CNT_ONE;
        end else begin
          exp_nxt = base;
        end
        // Only a genuine max->0 step of the model counts as a wrap, never a reload.
        if (!reload && !dut_reset && enable && (expected == CNT_MAX)) begin
          wrap_nxt = wrap_count + 8'd1;
        end
        if (err_nxt >= ERR_LIM) begin
          state_nxt = S_FAIL;
        end
      end
      S_FAIL: begin
        state_nxt = S_FAIL;
      end
      default: begin
        state_nxt = S_UNSYNC;
      end
    endcase
  end

  // Model value, mismatch pulse and statistics registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected    <= '0;
      mismatch    <= 1'b0;
      error_count <= '0;
      wrap_count  <= '0;
      first_bad   <= '0;
      first_exp   <= '0;
    end else begin
      expected    <= exp_nxt;
      mismatch    <= mm_nxt;
      error_count <= err_nxt;
      wrap_count  <= wrap_nxt;
      first_bad   <= fb_nxt;
      first_exp   <= fe_nxt;
    end
  end

endmodule

// File: tb/tb_first_counter_checker.sv
// tb/tb_first_counter_checker.sv - vector-table bench for first_counter_checker
module tb_first_counter_checker;

  logic       clk;
  logic       reset;
  logic       dut_reset;
  logic       enable;
  logic [3:0] counter_out;
  logic       in_sync;
  logic [3:0] expected;
  logic       mismatch;
  logic [7:0] error_count;
  logic [7:0] wrap_count;
  logic [3:0] first_bad;
  logic [3:0] first_exp;
  logic       fail;

  int n_total = 0;
  int n_bad   = 0;

  first_counter_checker #(
    .WIDTH(4), .ERR_W(8), .ERR_LIMIT(4), .RESYNC(1)
  ) dut (
    .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
    .counter_out(counter_out), .in_sync(in_sync), .expected(expected),
    .mismatch(mismatch), .error_count(error_count), .wrap_count(wrap_count),
    .first_bad(first_bad), .first_exp(first_exp), .fail(fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dr;
    logic       en;
    logic [3:0] cnt;
    logic       sync;
    logic [3:0] exp;
    logic       mm;
    logic [7:0] err;
    logic [7:0] wrap;
    logic [3:0] fb;
    logic [3:0] fe;
    logic       fl;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic dr, logic en, int cnt, logic sync, int exp, logic mm,
                              int err, int wrap, int fb, int fe, logic fl);
    vec_t v;
    v.dr = dr; v.en = en; v.cnt = 4'(cnt); v.sync = sync; v.exp = 4'(exp); v.mm = mm;
    v.err = 8'(err); v.wrap = 8'(wrap); v.fb = 4'(fb); v.fe = 4'(fe); v.fl = fl;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".in_sync"}, 32'(in_sync), 0);
    chk({tag, ".expected"}, 32'(expected), 0);
    chk({tag, ".mismatch"}, 32'(mismatch), 0);
    chk({tag, ".error_count"}, 32'(error_count), 0);
    chk({tag, ".wrap_count"}, 32'(wrap_count), 0);
    chk({tag, ".first_bad"}, 32'(first_bad), 0);
    chk({tag, ".first_exp"}, 32'(first_exp), 0);
    chk({tag, ".fail"}, 32'(fail), 0);
  endtask

  task automatic run_range(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      dut_reset   = vecs[i].dr;
      enable      = vecs[i].en;
      counter_out = vecs[i].cnt;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.in_sync", i), 32'(in_sync), 32'(vecs[i].sync));
      chk($sformatf("v%0d.expected", i), 32'(expected), 32'(vecs[i].exp));
      chk($sformatf("v%0d.mismatch", i), 32'(mismatch), 32'(vecs[i].mm));
      chk($sformatf("v%0d.error_count", i), 32'(error_count), 32'(vecs[i].err));
      chk($sformatf("v%0d.wrap_count", i), 32'(wrap_count), 32'(vecs[i].wrap));
      chk($sformatf("v%0d.first_bad", i), 32'(first_bad), 32'(vecs[i].fb));
      chk($sformatf("v%0d.first_exp", i), 32'(first_exp), 32'(vecs[i].fe));
      chk($sformatf("v%0d.fail", i), 32'(fail), 32'(vecs[i].fl));
    end
  endtask

  // Async reset pulse between edges: outputs must clear before the next edge.
  task automatic async_reset(string tag);
    #1;
    reset = 1'b0;
    #1;
    chk_zero(tag);
    @(negedge clk);
    dut_reset = 1'b0;
    reset     = 1'b1;
  endtask

  initial begin
    int a_end;
    int b_end;
    int c_end;

    // args: dr en cnt | in_sync expected mismatch err wrap first_bad first_exp fail
    // Sync, clean count through one wrap (expected ends at 4).
    add(0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 7,  1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      add(0, 1, k % 16,  1, (k + 1) % 16, 0, 0, (k >= 15) ? 1 : 0, 0, 0, 0);
    end
    // Single fault: 5 observed while 4 expected, model reloads to 6.
    add(0, 1, 5,  1, 6, 1, 1, 1, 5, 4, 0);
    for (int k = 6; k < 15; k++) begin
      add(0, 1, k,  1, k + 1, 0, 1, 1, 5, 4, 0);
    end
    // dut_reset together with enable at 15: reset wins, no wrap.
    add(1, 1, 15,  1, 0, 0, 1, 1, 5, 4, 0);
    add(0, 1, 0,   1, 1, 0, 1, 1, 5, 4, 0);
    add(0, 0, 1,   1, 1, 0, 1, 1, 5, 4, 0);
    a_end = vecs.size();

    // Fail path: counter stuck at 0 after a fresh sync.
    add(0, 1, 3,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 9,   1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0,   1, 1, 1, 1, 0, 0, 1, 0);
    add(0, 1, 0,   1, 1, 1, 2, 0, 0, 1, 0);
    add(0, 1, 0,   1, 1, 1, 3, 0, 0, 1, 0);
    add(0, 1, 0,   1, 1, 1, 4, 0, 0, 1, 1);
    add(0, 1, 0,   1, 1, 0, 4, 0, 0, 1, 1);
    add(1, 1, 0,   1, 1, 0, 4, 0, 0, 1, 1);
    add(0, 0, 15,  1, 1, 0, 4, 0, 0, 1, 1);
    b_end = vecs.size();

    // After reset in FAIL: stays unsynced until a dut_reset edge.
    add(0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4,   0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 5,   1, 0, 0, 0, 0, 0, 0, 0);
    c_end = vecs.size();

    reset       = 1'b0;
    dut_reset   = 1'b0;
    enable      = 1'b0;
    counter_out = 4'd0;
    #2;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    run_range(0, a_end);
    async_reset("rst_track");
    run_range(a_end, b_end);
    async_reset("rst_fail");
    run_range(b_end, c_end);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
